// File: rtl/wb_select_stage.sv
// Register-file write-back stage: picks a producer bus or returning load data, extracts and
// extends sub-word loads, and stalls upstream while a load waits on memory.
module wb_select_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NSRC   = 4,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned REG_AW = 5,
   localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
   input  logic                   CLK,
   input  logic                   Reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SEL_W-1:0]       src_sel,
   input  logic [NSRC*DATA_W-1:0] src_bus,
   input  logic                   is_load,
   input  logic [1:0]             load_size,
   input  logic                   load_signed,
   input  logic [OFF_W-1:0]       byte_off,
   input  logic                   wr_en_in,
   input  logic [REG_AW-1:0]      wr_addr_in,
   input  logic                   mem_valid,
   input  logic [DATA_W-1:0]      mem_data,
   input  logic                   flush,
   output logic                   out_wr_en,
   output logic [REG_AW-1:0]      out_wr_addr,
   output logic [DATA_W-1:0]      out_wr_data,
   output logic                   busy
);

   if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
      $error("wb_select_stage: DATA_W must be 32 or 64");
   end
   if ((2 ** SEL_W) < NSRC) begin : g_bad_sel_w
      $error("wb_select_stage: SEL_W too narrow for NSRC");
   end

   typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

   state_e state_q, state_d;

   logic              cap_wr_en_q, cap_wr_en_d;
   logic [REG_AW-1:0] cap_addr_q, cap_addr_d;
   logic [1:0]        cap_size_q, cap_size_d;
   logic              cap_signed_q, cap_signed_d;
   logic [OFF_W-1:0]  cap_off_q, cap_off_d;

   logic              out_wr_en_q, out_wr_en_d;
   logic [REG_AW-1:0] out_wr_addr_q, out_wr_addr_d;
   logic [DATA_W-1:0] out_wr_data_q, out_wr_data_d;

   logic              accept;
   logic [DATA_W-1:0] src_data;
   logic [DATA_W-1:0] ext_now;
   logic [DATA_W-1:0] ext_pend;

   // Halfword offset drops byte_off[0], so halfwords are always naturally aligned.
   function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d,
                                                 input logic [1:0]        size,
                                                 input logic              sgn,
                                                 input logic [OFF_W-1:0]  off);
      logic [7:0]       b;
      logic [15:0]      h;
      logic [OFF_W-1:0] hoff;
      logic [DATA_W-1:0] r;
      hoff = {off[OFF_W-1:1], 1'b0};
      b    = d[8*off +: 8];
      h    = d[8*hoff +: 16];
      unique case (size)
         2'b01:   r = {{(DATA_W-16){sgn & h[15]}}, h};
         2'b10:   r = {{(DATA_W-8){sgn & b[7]}}, b};
         default: r = d;
      endcase
      return r;
   endfunction

   always_comb begin
      src_data = '0;
      for (int unsigned k = 0; k < NSRC; k++) begin
         if (32'(src_sel) == k) begin
            src_data = src_bus[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      ext_now  = extract(mem_data, load_size, load_signed, byte_off);
      ext_pend = extract(mem_data, cap_size_q, cap_signed_q, cap_off_q);
      accept   = in_valid && in_ready;
   end

   // State register
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept && is_load && !mem_valid) begin
               state_d = StWaitMem;
            end
         end
         StWaitMem: begin
            if (flush || mem_valid) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs depend on state and flush only
   always_comb begin
      in_ready = (state_q == StIdle) && !flush;
      busy     = (state_q == StWaitMem);
   end

   always_comb begin
      cap_wr_en_d   = cap_wr_en_q;
      cap_addr_d    = cap_addr_q;
      cap_size_d    = cap_size_q;
      cap_signed_d  = cap_signed_q;
      cap_off_d     = cap_off_q;
      out_wr_en_d   = 1'b0;
      out_wr_addr_d = out_wr_addr_q;
      out_wr_data_d = out_wr_data_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!is_load || mem_valid) begin
                  out_wr_en_d   = wr_en_in && (wr_addr_in != '0);
                  out_wr_addr_d = wr_addr_in;
                  out_wr_data_d = is_load ? ext_now : src_data;
               end else begin
                  cap_wr_en_d  = wr_en_in;
                  cap_addr_d   = wr_addr_in;
                  cap_size_d   = load_size;
                  cap_signed_d = load_signed;
                  cap_off_d    = byte_off;
               end
            end
         end
         StWaitMem: begin
            // Flush beats returning data: the load is dropped.
            if (mem_valid && !flush) begin
               out_wr_en_d   = cap_wr_en_q && (cap_addr_q != '0);
               out_wr_addr_d = cap_addr_q;
               out_wr_data_d = ext_pend;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         cap_wr_en_q   <= 1'b0;
         cap_addr_q    <= '0;
         cap_size_q    <= '0;
         cap_signed_q  <= 1'b0;
         cap_off_q     <= '0;
         out_wr_en_q   <= 1'b0;
         out_wr_addr_q <= '0;
         out_wr_data_q <= '0;
      end else begin
         cap_wr_en_q   <= cap_wr_en_d;
         cap_addr_q    <= cap_addr_d;
         cap_size_q    <= cap_size_d;
         cap_signed_q  <= cap_signed_d;
         cap_off_q     <= cap_off_d;
         out_wr_en_q   <= out_wr_en_d;
         out_wr_addr_q <= out_wr_addr_d;
         out_wr_data_q <= out_wr_data_d;
      end
   end

   assign out_wr_en   = out_wr_en_q;
   assign out_wr_addr = out_wr_addr_q;
   assign out_wr_data = out_wr_data_q;

endmodule
